ext_unit_pipe: RTL and testbench
================================

Name: ext_unit_pipe

Overview:
- Parametrised, buffered successor to the CPU's immediate extender.
- Takes an IMM_W-bit immediate and a 3-bit extension mode and produces a DATA_W-bit operand.
- Output is registered behind a 2-entry valid/ready buffer, so the block can sit between the decode stage and the operand-select stage with back-pressure.
- Adds byte-extension modes, a configurable shift mode, and illegal-mode error reporting.

Parameters:
- IMM_W, 16, immediate width; legal range 8..DATA_W-1.
- DATA_W, 32, output operand width.
- SHL, 1, left-shift amount for mode 6; legal range 0..DATA_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- imm  input  IMM_W  immediate field.
- EOp  input  3  extension mode.
- out_valid  output  1  head entry holds a result.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_data  output  DATA_W  extended operand of the head entry.
- out_err  output  1  head entry was issued with an illegal mode.
- err_sticky  output  1  set if any illegal mode was ever accepted; cleared only by reset.

Behaviour:
- Modes, computed combinationally at acceptance and stored in the entry (S = sign extension of imm to DATA_W):
  - 0: S.
  - 1: zero extension.
  - 2: imm placed in the top bits, {imm, (DATA_W-IMM_W) zeros}.
  - 3: S << 2, truncated to DATA_W.
  - 4: imm[7:0] sign-extended; upper imm bits ignored.
  - 5: imm[7:0] zero-extended.
  - 6: S << SHL, truncated to DATA_W.
  - 7: illegal; data = 0, entry err bit = 1.
- Every mode result has exactly DATA_W bits; overflow from shifts is discarded.
- Storage: 2-entry FIFO with a count register holding 0..2, plus head/tail pointers that wrap modulo 2.
- Each entry holds {data, err}.
- Accept condition: in_valid && in_ready.
- in_ready = (count != 2). It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = (count != 0). out_data and out_err come from the head entry and are 0 when count = 0.
- Pop condition: out_valid && out_ready.
- Latency: a request accepted in cycle N appears on out_valid and out_data in cycle N+1 at the earliest.
- Ordering is strict FIFO.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count 1): count unchanged, head and tail both advance.
  - push and pop together (count 0): impossible, since out_valid = 0.
  - count 2: no push is possible; a pop takes count to 1 and in_ready rises the next cycle.
- Sustained throughput is one result per cycle while out_ready = 1.
- Inputs with in_valid = 0 are ignored regardless of the imm and EOp values.
- out_data holds stable while out_valid && !out_ready.
- err_sticky is set in the cycle after an accept with EOp = 7 and stays set.
- Reset (any cycle, including mid-stream):
  - count, pointers, err_sticky and all entries go to 0 in the next cycle.
  - Resulting outputs: out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
  - Any in-flight or buffered entries are discarded.
  - A request presented during the reset cycle is not accepted.

Test Plan:
- Mode sweep, defaults, out_ready = 1, imm = 16'h8080 with EOp 0..6 on consecutive cycles -> out_data must be, one cycle later each:
  - 0: FFFF8080
  - 1: 00008080
  - 2: 80800000
  - 3: FFFE0200
  - 4: FFFFFF80
  - 5: 00000080
  - 6: FFFF0100
- Illegal mode: imm = 16'h1234, EOp = 7 -> out_data = 0 and out_err = 1 for that entry; err_sticky = 1 from the next cycle onward; the following EOp = 1 entry gives 00001234 with out_err = 0.
- Back-pressure: out_ready = 0, push imm = 1 then imm = 2 (EOp 1) -> in_ready = 0 after the second accept and a third request is held off. Raise out_ready -> outputs 1 then 2 in order; in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop at count 1: continuous stream of 8 requests with out_ready = 1 -> one result per cycle, no drops or duplicates, count stays 1.
- Reset mid-stream: 2 entries buffered plus err_sticky = 1, assert reset for one cycle -> next cycle out_valid = 0, out_data = 0, err_sticky = 0, in_ready = 1; a request held on the inputs during the reset cycle never appears at the output.
- Parameter variant IMM_W = 12, DATA_W = 64, SHL = 3: imm = 12'h800, EOp 0 -> FFFFFFFFFFFFF800; EOp 2 -> 8000000000000000; EOp 6 -> FFFFFFFFFFFFC000.

Source files
------------

// File: rtl/ext_unit_pipe.sv
// Immediate extender with a 2-entry valid/ready output buffer.
// Results are computed at acceptance and stored as {data, err} entries.
module ext_unit_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHL    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        EOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              err_sticky
);

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] ext_val;
    logic              ext_err;

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [1:0]        err_q;
    logic [1:0]        err_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              sticky_q, sticky_d;

    logic push;
    logic pop;

    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        ext_val = '0;
        ext_err = 1'b0;
        case (EOp)
            3'd0: ext_val = sext;
            3'd1: ext_val = {{(DATA_W-IMM_W){1'b0}}, imm};
            3'd2: ext_val = {imm, {(DATA_W-IMM_W){1'b0}}};
            3'd3: ext_val = sext << 2;
            3'd4: ext_val = {{(DATA_W-8){imm[7]}}, imm[7:0]};
            3'd5: ext_val = {{(DATA_W-8){1'b0}}, imm[7:0]};
            3'd6: ext_val = sext << SHL;
            default: begin
                ext_val = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    // Handshake flags depend only on the registered count.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? data_q[head_q] : '0;
    assign out_err   = out_valid ? err_q[head_q] : 1'b0;
    assign err_sticky = sticky_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        data_d   = data_q;
        err_d    = err_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        sticky_d = sticky_q | (push && ext_err);
        if (push) begin
            data_d[tail_q] = ext_val;
            err_d[tail_q]  = ext_err;
            tail_d         = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '{default: '0};
            err_q    <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            sticky_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            err_q    <= err_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: default instance against a queue
// reference model, plus a 12/64/3 parameter variant.
module tb_ext_unit_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  EOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        err_sticky;

    logic        v_in_valid;
    logic        v_in_ready;
    logic [11:0] v_imm;
    logic [2:0]  v_EOp;
    logic        v_out_valid;
    logic        v_out_ready;
    logic [63:0] v_out_data;
    logic        v_out_err;
    logic        v_err_sticky;

    int checks = 0;
    int failures = 0;

    logic [63:0] q_data[$];
    logic        q_err[$];
    logic        sticky_m;

    always #5 clk = ~clk;

    ext_unit_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .EOp(EOp), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .err_sticky(err_sticky)
    );

    ext_unit_pipe #(.IMM_W(12), .DATA_W(64), .SHL(3)) dut_v (
        .clk(clk), .reset(reset), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .imm(v_imm), .EOp(v_EOp), .out_valid(v_out_valid), .out_ready(v_out_ready),
        .out_data(v_out_data), .out_err(v_out_err), .err_sticky(v_err_sticky)
    );

    // Arithmetic reference for the extension modes at any width.
    function automatic logic [63:0] ref_ext(int iw, int dw, int shl,
                                            logic [63:0] val, int op);
        logic [63:0] s, b, mask, r;
        mask = (dw == 64) ? ~64'd0 : ((64'd1 << dw) - 64'd1);
        s = val;
        if (((val >> (iw - 1)) & 64'd1) == 64'd1) s = val | (~64'd0 << iw);
        b = val & 64'd255;
        r = 64'd0;
        case (op)
            0: r = s;
            1: r = val;
            2: r = val * (64'd1 << (dw - iw));
            3: r = s * 64'd4;
            4: r = (b >= 64'd128) ? (b | (~64'd0 << 8)) : b;
            5: r = b;
            6: r = s * (64'd1 << shl);
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check registered outputs against the model, then clock and advance the model.
    task automatic tick();
        logic acc, pp;
        chk("in_ready", in_ready, q_data.size() != 2);
        chk("out_valid", out_valid, q_data.size() != 0);
        chk("out_data", out_data, (q_data.size() != 0) ? q_data[0] : 64'd0);
        chk("out_err", out_err, (q_err.size() != 0) ? q_err[0] : 1'b0);
        chk("err_sticky", err_sticky, sticky_m);
        acc = in_valid && (q_data.size() < 2);
        pp  = out_ready && (q_data.size() > 0);
        @(posedge clk);
        if (reset) begin
            q_data.delete();
            q_err.delete();
            sticky_m = 1'b0;
        end else begin
            if (pp) begin
                void'(q_data.pop_front());
                void'(q_err.pop_front());
            end
            if (acc) begin
                q_data.push_back(ref_ext(16, 32, 1, {48'd0, imm}, int'(EOp)));
                q_err.push_back(EOp == 3'd7);
                if (EOp == 3'd7) sticky_m = 1'b1;
            end
        end
        #1;
    endtask

    logic [31:0] sweep_exp [7];
    logic [31:0] want;

    initial begin
        sweep_exp = '{32'hFFFF8080, 32'h00008080, 32'h80800000, 32'hFFFE0200,
                      32'hFFFFFF80, 32'h00000080, 32'hFFFF0100};
        reset = 1'b1; in_valid = 1'b0; imm = '0; EOp = '0; out_ready = 1'b0;
        v_in_valid = 1'b0; v_imm = '0; v_EOp = '0; v_out_ready = 1'b1;
        sticky_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Mode sweep
        out_ready = 1'b1; in_valid = 1'b1; imm = 16'h8080;
        for (int i = 0; i < 7; i++) begin
            EOp = 3'(i);
            tick();
            chk($sformatf("sweep_mode%0d", i), out_data, sweep_exp[i]);
        end

        // Illegal mode then a legal one
        imm = 16'h1234; EOp = 3'd7;
        tick();
        chk("illegal_data", out_data, 32'd0);
        chk("illegal_err", out_err, 1'b1);
        chk("illegal_sticky", err_sticky, 1'b1);
        EOp = 3'd1;
        tick();
        chk("after_illegal_data", out_data, 32'h00001234);
        chk("after_illegal_err", out_err, 1'b0);
        chk("sticky_held", err_sticky, 1'b1);
        in_valid = 1'b0;
        tick();

        // Back-pressure
        out_ready = 1'b0; in_valid = 1'b1; EOp = 3'd1; imm = 16'd1;
        tick();
        imm = 16'd2;
        tick();
        chk("bp_full_ready", in_ready, 1'b0);
        imm = 16'd3;
        tick();
        chk("bp_held_ready", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_first", out_data, 32'd1);
        tick();
        chk("bp_ready_back", in_ready, 1'b1);
        chk("bp_second", out_data, 32'd2);
        tick();
        chk("bp_drained", out_valid, 1'b0);

        // Continuous stream, push and pop together at count 1
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imm = 16'($urandom);
            EOp = 3'($urandom_range(0, 6));
            want = 32'(ref_ext(16, 32, 1, {48'd0, imm}, int'(EOp)));
            tick();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_data", out_data, want);
            chk("stream_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();

        // Reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; imm = 16'h00FF; EOp = 3'd7;
        tick();
        EOp = 3'd1;
        tick();
        chk("pre_reset_sticky", err_sticky, 1'b1);
        reset = 1'b1; imm = 16'hABCD; EOp = 3'd1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sticky", err_sticky, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("rst_req_dropped", out_valid, 1'b0);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            imm       = 16'($urandom);
            EOp       = 3'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0;
        tick();

        // Parameter variant IMM_W=12, DATA_W=64, SHL=3
        v_in_valid = 1'b1; v_imm = 12'h800;
        v_EOp = 3'd0; @(posedge clk); #1;
        chk("v_mode0", v_out_data, 64'hFFFFFFFFFFFFF800);
        v_EOp = 3'd2; @(posedge clk); #1;
        chk("v_mode2", v_out_data, 64'h8000000000000000);
        v_EOp = 3'd6; @(posedge clk); #1;
        chk("v_mode6", v_out_data, 64'hFFFFFFFFFFFFC000);
        for (int i = 0; i < 24; i++) begin
            v_imm = 12'($urandom);
            v_EOp = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            chk("v_rand_data", v_out_data, ref_ext(12, 64, 3, {52'd0, v_imm}, int'(v_EOp)));
            chk("v_rand_err", v_out_err, v_EOp == 3'd7);
        end
        v_in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
